// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the parametrised up/down counter.
// The optional prescaler is enabled by defining CNT_PRESCALE_EN.
package mod_counter_pkg;

  localparam int CNT_MODE_W        = 2;
  localparam int CNT_DEFAULT_WIDTH = 8;
  localparam int CNT_DEFAULT_PRE_W = 8;

  // 2'b11 is reserved and decodes as CNT_WRAP.
  typedef enum logic [CNT_MODE_W-1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10
  } cnt_mode_e;

  // True for the modes that stop at a terminal value instead of rolling over.
  function automatic logic mode_stops(input logic [CNT_MODE_W-1:0] mode);
    return (mode == CNT_SAT) || (mode == CNT_ONESHOT);
  endfunction

endpackage

// File: rtl/mod_updown_counter_prescaler.sv
// Cycle prescaler for the up/down counter: tick fires once every presc+1 running cycles.
// Only instantiated when CNT_PRESCALE_EN is defined.
module cnt_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [PRE_W-1:0] presc,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  assign tick = (pre_q == presc);

  // restart wins over run so that clr/load always realign the phase.
  always_comb begin
    pre_d = pre_q;
    if (restart) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down/load counter with modulo limit, wrap/saturate/one-shot modes.
// Define CNT_PRESCALE_EN to add the presc port and a step prescaler.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = CNT_DEFAULT_WIDTH,
  parameter int PRE_W = CNT_DEFAULT_PRE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [CNT_MODE_W-1:0] mode,
  input  logic                  out_en,
`ifdef CNT_PRESCALE_EN
  input  logic [PRE_W-1:0]      presc,
`endif
  output logic [WIDTH-1:0]      count,
  output logic [WIDTH-1:0]      cnt_out,
  output logic                  tc,
  output logic                  done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic             tc_q;
  logic             tc_d;
  logic             done_q;
  logic             done_d;
  logic             tick;
  logic             step;
  logic             stop_mode;
  logic             oneshot;

`ifdef CNT_PRESCALE_EN
  cnt_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (ena & en & ~done_q),
    .restart(ena & (clr | load)),
    .presc  (presc),
    .tick   (tick)
  );
`else
  // Without a prescaler every enabled cycle is a step opportunity.
  localparam logic NoPrescTick = (PRE_W > 0);
  assign tick = NoPrescTick;
`endif

  assign count_inc = count_q + WIDTH'(1);
  assign count_dec = count_q - WIDTH'(1);
  assign stop_mode = mode_stops(mode);
  assign oneshot   = (mode == CNT_ONESHOT);
  assign step      = en & tick & ~done_q;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (ena) begin
      if (clr) begin
        count_d = '0;
        done_d  = 1'b0;
      end else if (load) begin
        count_d = load_val;
        done_d  = 1'b0;
      end else if (step) begin
        if (up) begin
          if (count_q < limit) begin
            count_d = count_inc;
            if (stop_mode && (count_inc == limit)) begin
              tc_d   = 1'b1;
              done_d = oneshot;
            end
          end else begin
            // At or above the limit (the latter only after a load).
            case (mode)
              CNT_SAT: begin
                count_d = count_q;
              end
              CNT_ONESHOT: begin
                done_d = 1'b1;
                tc_d   = 1'b1;
              end
              default: begin
                count_d = '0;
                tc_d    = 1'b1;
              end
            endcase
          end
        end else begin
          if (count_q != '0) begin
            count_d = count_dec;
            if (stop_mode && (count_dec == '0)) begin
              tc_d   = 1'b1;
              done_d = oneshot;
            end
          end else begin
            case (mode)
              CNT_SAT: begin
                count_d = count_q;
              end
              CNT_ONESHOT: begin
                done_d = 1'b1;
                tc_d   = 1'b1;
              end
              default: begin
                count_d = limit;
                tc_d    = 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign cnt_out = (ena & out_en) ? count_q : '0;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter (WIDTH=8); prescaler scenario runs when CNT_PRESCALE_EN is defined.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clr;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [1:0] mode;
  logic       out_en;
  logic [7:0] count;
  logic [7:0] cnt_out;
  logic       tc;
  logic       done;
`ifdef CNT_PRESCALE_EN
  logic [7:0] presc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mod_updown_counter #(
    .WIDTH(8),
    .PRE_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .clr     (clr),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .limit   (limit),
    .mode    (mode),
    .out_en  (out_en),
`ifdef CNT_PRESCALE_EN
    .presc   (presc),
`endif
    .count   (count),
    .cnt_out (cnt_out),
    .tc      (tc),
    .done    (done)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1; en = 1'b0; load = 1'b0;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; out_en = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1;
    load = 1'b0; load_val = 8'd0; limit = 8'hFF; mode = 2'b00;
    cycle();
    n_checks += 4;
    if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0h want 0", count); end
    if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %0b want 0", tc); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_out: got %0h want 0", cnt_out); end
    rst_n = 1'b1; en = 1'b1;
    repeat (3) cycle();
    n_checks += 2;
    if (count !== 8'd3) begin n_fail++; $display("FAIL gate_count: got %0h want 3", count); end
    if (cnt_out !== 8'd3) begin n_fail++; $display("FAIL gate_on: got %0h want 3", cnt_out); end
    out_en = 1'b0; #1;
    n_checks++;
    if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL gate_out_en_off: got %0h want 0", cnt_out); end
    out_en = 1'b1; ena = 1'b0; #1;
    n_checks++;
    if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL gate_ena_off: got %0h want 0", cnt_out); end
    @(negedge clk);
    cycle();
    n_checks++;
    if (count !== 8'd3) begin n_fail++; $display("FAIL ena_hold: got %0h want 3", count); end
    ena = 1'b1;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (count !== 8'd0) begin n_fail++; $display("FAIL async_reset_count: got %0h want 0", count); end
    if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL async_reset_cnt_out: got %0h want 0", cnt_out); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] ec[6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    logic       et[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_clear();
    mode = 2'b00; limit = 8'd5; up = 1'b1; en = 1'b1;
    et[4] = 1'b0; et[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks += 2;
      if (count !== ec[i]) begin n_fail++; $display("FAIL wrap_up_count[%0d]: got %0h want %0h", i, count, ec[i]); end
      if (tc !== et[i]) begin n_fail++; $display("FAIL wrap_up_tc[%0d]: got %0b want %0b", i, tc, et[i]); end
    end
    up = 1'b0;
    cycle();
    n_checks += 2;
    if (count !== 8'd5) begin n_fail++; $display("FAIL wrap_down_count: got %0h want 5", count); end
    if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_down_tc: got %0b want 1", tc); end
    cycle();
    n_checks += 2;
    if (count !== 8'd4) begin n_fail++; $display("FAIL wrap_down2_count: got %0h want 4", count); end
    if (tc !== 1'b0) begin n_fail++; $display("FAIL wrap_down2_tc: got %0b want 0", tc); end
    en = 1'b0;
  endtask

  task automatic test_sat();
    logic [7:0] ec[12] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3,
                           8'd2, 8'd1, 8'd0, 8'd0};
    logic       et[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b1, 1'b0};
    do_clear();
    mode = 2'b01; limit = 8'd3; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) up = 1'b0;
      cycle();
      n_checks += 2;
      if (count !== ec[i]) begin n_fail++; $display("FAIL sat_count[%0d]: got %0h want %0h", i, count, ec[i]); end
      if (tc !== et[i]) begin n_fail++; $display("FAIL sat_tc[%0d]: got %0b want %0b", i, tc, et[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] ec[4] = '{8'd2, 8'd3, 8'd4, 8'd4};
    logic       et[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       ed[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_clear();
    mode = 2'b10; limit = 8'd4; up = 1'b1; en = 1'b1; load_val = 8'd2;
    for (int i = 0; i < 4; i++) begin
      load = (i == 0);
      cycle();
      n_checks += 3;
      if (count !== ec[i]) begin n_fail++; $display("FAIL oneshot_count[%0d]: got %0h want %0h", i, count, ec[i]); end
      if (tc !== et[i]) begin n_fail++; $display("FAIL oneshot_tc[%0d]: got %0b want %0b", i, tc, et[i]); end
      if (done !== ed[i]) begin n_fail++; $display("FAIL oneshot_done[%0d]: got %0b want %0b", i, done, ed[i]); end
    end
    mode = 2'b00;
    cycle();
    n_checks += 2;
    if (count !== 8'd4) begin n_fail++; $display("FAIL oneshot_mode_change_count: got %0h want 4", count); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL oneshot_mode_change_done: got %0b want 1", done); end
    mode = 2'b10; load = 1'b1;
    cycle();
    load = 1'b0;
    n_checks += 2;
    if (count !== 8'd2) begin n_fail++; $display("FAIL oneshot_reload_count: got %0h want 2", count); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL oneshot_reload_done: got %0b want 0", done); end
    // Down to zero then an extra step from zero.
    do_clear();
    up = 1'b0; en = 1'b1;
    cycle();
    n_checks += 3;
    if (count !== 8'd0) begin n_fail++; $display("FAIL oneshot_zero_count: got %0h want 0", count); end
    if (tc !== 1'b1) begin n_fail++; $display("FAIL oneshot_zero_tc: got %0b want 1", tc); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL oneshot_zero_done: got %0b want 1", done); end
    en = 1'b0;
  endtask

  task automatic test_priority();
    mode = 2'b00; limit = 8'h10; up = 1'b1; load_val = 8'hFE;
    clr = 1'b1; load = 1'b1; en = 1'b1;
    cycle();
    n_checks++;
    if (count !== 8'd0) begin n_fail++; $display("FAIL prio_clr_count: got %0h want 0", count); end
    clr = 1'b0;
    cycle();
    n_checks += 2;
    if (count !== 8'hFE) begin n_fail++; $display("FAIL prio_load_count: got %0h want fe", count); end
    if (tc !== 1'b0) begin n_fail++; $display("FAIL prio_load_tc: got %0b want 0", tc); end
    load = 1'b0;
    cycle();
    n_checks += 2;
    if (count !== 8'd0) begin n_fail++; $display("FAIL above_limit_wrap_count: got %0h want 0", count); end
    if (tc !== 1'b1) begin n_fail++; $display("FAIL above_limit_wrap_tc: got %0b want 1", tc); end
    en = 1'b0;
  endtask

  task automatic test_boundaries();
    do_clear();
    mode = 2'b00; limit = 8'd0; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      up = (i == 0);
      cycle();
      n_checks += 2;
      if (count !== 8'd0) begin n_fail++; $display("FAIL limit0_count[%0d]: got %0h want 0", i, count); end
      if (tc !== 1'b1) begin n_fail++; $display("FAIL limit0_tc[%0d]: got %0b want 1", i, tc); end
    end
    limit = 8'hFF; up = 1'b1; load_val = 8'hFE; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    n_checks += 2;
    if (count !== 8'hFF) begin n_fail++; $display("FAIL full_range_top: got %0h want ff", count); end
    if (tc !== 1'b0) begin n_fail++; $display("FAIL full_range_top_tc: got %0b want 0", tc); end
    cycle();
    n_checks += 2;
    if (count !== 8'h00) begin n_fail++; $display("FAIL full_range_wrap: got %0h want 0", count); end
    if (tc !== 1'b1) begin n_fail++; $display("FAIL full_range_wrap_tc: got %0b want 1", tc); end
    up = 1'b0;
    cycle();
    n_checks += 2;
    if (count !== 8'hFF) begin n_fail++; $display("FAIL full_range_under: got %0h want ff", count); end
    if (tc !== 1'b1) begin n_fail++; $display("FAIL full_range_under_tc: got %0b want 1", tc); end
    en = 1'b0;
  endtask

`ifdef CNT_PRESCALE_EN
  task automatic test_prescale();
    logic [7:0] ec[16] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2,
                           8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3,
                           8'd10, 8'd10, 8'd10};
    presc = 8'd2;
    do_clear();
    mode = 2'b00; limit = 8'hFF; up = 1'b1; load_val = 8'd10;
    for (int i = 0; i < 16; i++) begin
      en   = !(i >= 7 && i <= 10);
      load = (i == 13);
      cycle();
      n_checks++;
      if (count !== ec[i]) begin n_fail++; $display("FAIL presc_count[%0d]: got %0h want %0h", i, count, ec[i]); end
    end
    load = 1'b0;
    cycle();
    n_checks++;
    if (count !== 8'd11) begin n_fail++; $display("FAIL presc_after_load: got %0h want 11", count); end
    en = 1'b0;
  endtask
`endif

  initial begin
`ifdef CNT_PRESCALE_EN
    presc = 8'd0;
`endif
    test_reset();
    test_wrap();
    test_sat();
    test_oneshot();
    test_priority();
    test_boundaries();
`ifdef CNT_PRESCALE_EN
    test_prescale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
